// File: rtl/systolic_input_feeder.sv
// systolic_input_feeder
//
// Upstream stage of the PE array. It accepts one A tile (N rows x K) and one
// B tile (K x N columns) through a valid/ready handshake. It then replays
// them as diagonally skewed, zero-padded operand streams, one element per
// lane per cycle, with acc_en_o high on every streamed beat. After that it
// waits for the array's done pulse before it accepts another tile.
//
// Ports:
//   clk           clock; all state updates on the rising edge
//   rstn          asynchronous active-low reset
//   load_valid_i  tile_a_i / tile_b_i carry a valid tile
//   load_ready_o  feeder can accept a tile (IDLE only)
//   tile_a_i      A[i][k] at [(i*K+k)*MAC_WIDTH +: MAC_WIDTH]
//   tile_b_i      B[k][j] at [(k*N+j)*MAC_WIDTH +: MAC_WIDTH]
//   data_a_o      registered A stream, lane i at [i*MAC_WIDTH +: MAC_WIDTH]
//   data_b_o      registered B stream, lane j at [j*MAC_WIDTH +: MAC_WIDTH]
//   acc_en_o      PE accumulate enable, high on every streamed beat
//   pe_done_i     done pulse from the PE array (sampled in WAIT_DONE only)
//   busy_o        high while streaming or waiting for done
//   tile_done_o   one-cycle pulse when the tile is fully processed
module systolic_input_feeder #(
  parameter int MAC_WIDTH = 9,
  parameter int N         = 2,
  parameter int K         = 2
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     load_valid_i,
  output logic                     load_ready_o,
  input  logic [N*K*MAC_WIDTH-1:0] tile_a_i,
  input  logic [K*N*MAC_WIDTH-1:0] tile_b_i,
  output logic [N*MAC_WIDTH-1:0]   data_a_o,
  output logic [N*MAC_WIDTH-1:0]   data_b_o,
  output logic                     acc_en_o,
  input  logic                     pe_done_i,
  output logic                     busy_o,
  output logic                     tile_done_o
);

  localparam int BEATS = K + N - 1;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_STREAM    = 2'd1;
  localparam logic [1:0] ST_WAIT_DONE = 2'd2;

  logic [1:0]               state_q, state_d;
  logic [CW-1:0]            t_q, t_d;
  logic [N*K*MAC_WIDTH-1:0] tile_a_q, tile_a_d;
  logic [K*N*MAC_WIDTH-1:0] tile_b_q, tile_b_d;
  logic [N*MAC_WIDTH-1:0]   data_a_q, data_a_d;
  logic [N*MAC_WIDTH-1:0]   data_b_q, data_b_d;
  logic                     acc_en_q, acc_en_d;
  logic                     busy_q, busy_d;
  logic                     tile_done_q, tile_done_d;

  logic [N*K*MAC_WIDTH-1:0] src_a;
  logic [K*N*MAC_WIDTH-1:0] src_b;
  logic [CW-1:0]            beat_t;
  logic [N*MAC_WIDTH-1:0]   skew_a;
  logic [N*MAC_WIDTH-1:0]   skew_b;

  // Values for the beat that gets loaded on the coming edge. On the
  // handshake edge the tile is not yet captured, so beat 0 is taken straight
  // from the inputs. While streaming, the next beat comes from the captured
  // copy. Lane i of A is delayed by i beats and lane j of B by j beats.
  // Positions outside the tile are zero padding.
  always_comb begin
    int kk;
    kk     = 0;
    src_a  = (state_q == ST_IDLE) ? tile_a_i : tile_a_q;
    src_b  = (state_q == ST_IDLE) ? tile_b_i : tile_b_q;
    beat_t = (state_q == ST_IDLE) ? '0 : t_q + 1'b1;
    skew_a = '0;
    skew_b = '0;
    for (int i = 0; i < N; i++) begin
      kk = int'(beat_t) - i;
      if (kk >= 0 && kk < K) begin
        skew_a[i*MAC_WIDTH +: MAC_WIDTH] = src_a[(i*K + kk)*MAC_WIDTH +: MAC_WIDTH];
        skew_b[i*MAC_WIDTH +: MAC_WIDTH] = src_b[(kk*N + i)*MAC_WIDTH +: MAC_WIDTH];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    t_d         = t_q;
    tile_a_d    = tile_a_q;
    tile_b_d    = tile_b_q;
    data_a_d    = data_a_q;
    data_b_d    = data_b_q;
    acc_en_d    = acc_en_q;
    busy_d      = busy_q;
    tile_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load_valid_i) begin
          tile_a_d = tile_a_i;
          tile_b_d = tile_b_i;
          t_d      = '0;
          data_a_d = skew_a;
          data_b_d = skew_b;
          acc_en_d = 1'b1;
          busy_d   = 1'b1;
          state_d  = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (t_q == LAST_BEAT) begin
          data_a_d = '0;
          data_b_d = '0;
          acc_en_d = 1'b0;
          state_d  = ST_WAIT_DONE;
        end else begin
          t_d      = t_q + 1'b1;
          data_a_d = skew_a;
          data_b_d = skew_b;
        end
      end
      ST_WAIT_DONE: begin
        if (pe_done_i) begin
          tile_done_d = 1'b1;
          busy_d      = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      t_q         <= '0;
      tile_a_q    <= '0;
      tile_b_q    <= '0;
      data_a_q    <= '0;
      data_b_q    <= '0;
      acc_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      tile_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      t_q         <= t_d;
      tile_a_q    <= tile_a_d;
      tile_b_q    <= tile_b_d;
      data_a_q    <= data_a_d;
      data_b_q    <= data_b_d;
      acc_en_q    <= acc_en_d;
      busy_q      <= busy_d;
      tile_done_q <= tile_done_d;
    end
  end

  // Ready is gated by rstn so that it stays low while reset is held.
  assign load_ready_o = (state_q == ST_IDLE) && rstn;
  assign data_a_o     = data_a_q;
  assign data_b_o     = data_b_q;
  assign acc_en_o     = acc_en_q;
  assign busy_o       = busy_q;
  assign tile_done_o  = tile_done_q;

endmodule

// File: tb/tb_systolic_input_feeder.sv
// tb_systolic_input_feeder
//
// Directed plus randomized bench for systolic_input_feeder. Expected streams
// come from the A/B matrices using the skew rule: lane i of A at beat t
// carries A[i][t-i], and lane j of B carries B[t-j][j]. Positions outside the
// tile read as zero.
module tb_systolic_input_feeder;

  localparam int MW    = 9;
  localparam int N     = 2;
  localparam int K     = 2;
  localparam int BEATS = N + K - 1;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              load_valid_i = 1'b0;
  logic              load_ready_o;
  logic [N*K*MW-1:0] tile_a_i = '0;
  logic [K*N*MW-1:0] tile_b_i = '0;
  logic [N*MW-1:0]   data_a_o;
  logic [N*MW-1:0]   data_b_o;
  logic              acc_en_o;
  logic              pe_done_i = 1'b0;
  logic              busy_o;
  logic              tile_done_o;

  always #5 clk = ~clk;

  systolic_input_feeder #(.MAC_WIDTH(MW), .N(N), .K(K)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .load_valid_i (load_valid_i),
    .load_ready_o (load_ready_o),
    .tile_a_i     (tile_a_i),
    .tile_b_i     (tile_b_i),
    .data_a_o     (data_a_o),
    .data_b_o     (data_b_o),
    .acc_en_o     (acc_en_o),
    .pe_done_i    (pe_done_i),
    .busy_o       (busy_o),
    .tile_done_o  (tile_done_o)
  );

  int total = 0;
  int bad   = 0;

  logic [MW-1:0]   ma [N][K];
  logic [MW-1:0]   mb [K][N];
  logic [N*MW-1:0] qa [$];
  logic [N*MW-1:0] qb [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N*MW-1:0] beat_a(input int t);
    logic [N*MW-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++)
      if (t - i >= 0 && t - i < K) v[i*MW +: MW] = ma[i][t-i];
    return v;
  endfunction

  function automatic logic [N*MW-1:0] beat_b(input int t);
    logic [N*MW-1:0] v;
    v = '0;
    for (int j = 0; j < N; j++)
      if (t - j >= 0 && t - j < K) v[j*MW +: MW] = mb[t-j][j];
    return v;
  endfunction

  task automatic rand_tile();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < K; k++) begin
        ma[i][k] = MW'($urandom);
        mb[k][i] = MW'($urandom);
      end
  endtask

  // Drive the matrices onto the tile inputs and queue their expected beats
  task automatic apply_stimulus();
    logic [N*K*MW-1:0] pa;
    logic [K*N*MW-1:0] pb;
    pa = '0;
    pb = '0;
    for (int i = 0; i < N; i++)
      for (int k = 0; k < K; k++) begin
        pa[(i*K+k)*MW +: MW] = ma[i][k];
        pb[(k*N+i)*MW +: MW] = mb[k][i];
      end
    tile_a_i = pa;
    tile_b_i = pb;
    for (int t = 0; t < BEATS; t++) begin
      qa.push_back(beat_a(t));
      qb.push_back(beat_b(t));
    end
  endtask

  task automatic handshake(input bit hold);
    load_valid_i = 1'b1;
    check("ready_before_load", 32'(load_ready_o), 32'd1);
    @(negedge clk);
    if (!hold) load_valid_i = 1'b0;
  endtask

  // Called at the negedge where beat 0 is visible
  task automatic check_output(input string tag, input int pulse_beat);
    logic [N*MW-1:0] ea, eb;
    for (int t = 0; t < BEATS; t++) begin
      ea = qa.pop_front();
      eb = qb.pop_front();
      check({tag, "_data_a"}, 32'(data_a_o), 32'(ea));
      check({tag, "_data_b"}, 32'(data_b_o), 32'(eb));
      check({tag, "_acc_en"}, 32'(acc_en_o), 32'd1);
      check({tag, "_busy"}, 32'(busy_o), 32'd1);
      check({tag, "_ready_low"}, 32'(load_ready_o), 32'd0);
      check({tag, "_no_done"}, 32'(tile_done_o), 32'd0);
      pe_done_i = (t == pulse_beat);
      @(negedge clk);
    end
    pe_done_i = 1'b0;
    check({tag, "_tail_a"}, 32'(data_a_o), 32'd0);
    check({tag, "_tail_b"}, 32'(data_b_o), 32'd0);
    check({tag, "_tail_acc"}, 32'(acc_en_o), 32'd0);
    check({tag, "_tail_busy"}, 32'(busy_o), 32'd1);
  endtask

  task automatic finish_tile(input string tag, input int waits, input bit hold);
    repeat (waits) begin
      check({tag, "_wait_busy"}, 32'(busy_o), 32'd1);
      check({tag, "_wait_done"}, 32'(tile_done_o), 32'd0);
      check({tag, "_wait_ready"}, 32'(load_ready_o), 32'd0);
      check({tag, "_wait_acc"}, 32'(acc_en_o), 32'd0);
      @(negedge clk);
    end
    pe_done_i = 1'b1;
    @(negedge clk);
    pe_done_i = 1'b0;
    check({tag, "_done_pulse"}, 32'(tile_done_o), 32'd1);
    check({tag, "_done_ready"}, 32'(load_ready_o), 32'd1);
    check({tag, "_done_busy"}, 32'(busy_o), 32'd0);
    if (!hold) begin
      @(negedge clk);
      check({tag, "_done_once"}, 32'(tile_done_o), 32'd0);
      check({tag, "_idle_ready"}, 32'(load_ready_o), 32'd1);
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_data_a", 32'(data_a_o), 32'd0);
    check("rst_data_b", 32'(data_b_o), 32'd0);
    check("rst_acc", 32'(acc_en_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(tile_done_o), 32'd0);
    rstn = 1'b1;
    #1;
    check("rst_ready_after", 32'(load_ready_o), 32'd1);
    @(negedge clk);

    // Basic skew
    ma = '{'{9'd1, 9'd2}, '{9'd3, 9'd4}};
    mb = '{'{9'd5, 9'd6}, '{9'd7, 9'd8}};
    apply_stimulus();
    handshake(1'b0);
    check_output("basic", -1);
    finish_tile("basic", 2, 1'b0);

    // All ones, done arrives several cycles later
    ma = '{'{9'd1, 9'd1}, '{9'd1, 9'd1}};
    mb = '{'{9'd1, 9'd1}, '{9'd1, 9'd1}};
    apply_stimulus();
    handshake(1'b0);
    check_output("ones", -1);
    finish_tile("ones", 4, 1'b0);

    // Negative operands pass bit-exact
    rand_tile();
    ma[0][0] = 9'h1FF;
    mb[0][0] = 9'h100;
    apply_stimulus();
    handshake(1'b0);
    check_output("neg", -1);
    finish_tile("neg", 0, 1'b0);

    // pe_done during streaming is ignored
    rand_tile();
    apply_stimulus();
    handshake(1'b0);
    check_output("pe_ignore", 1);
    finish_tile("pe_ignore", 1, 1'b0);

    // load_valid held high with a different tile waiting behind
    rand_tile();
    apply_stimulus();
    handshake(1'b1);
    rand_tile();
    apply_stimulus();
    check_output("hold1", -1);
    finish_tile("hold1", 3, 1'b1);
    @(negedge clk);
    load_valid_i = 1'b0;
    check_output("hold2", -1);
    finish_tile("hold2", 1, 1'b0);

    // Reset at beat 1 of streaming
    rand_tile();
    ma[0][1] = 9'h0AA;
    apply_stimulus();
    handshake(1'b0);
    @(negedge clk);
    #1 rstn = 1'b0;
    #1;
    check("midrst_data_a", 32'(data_a_o), 32'd0);
    check("midrst_data_b", 32'(data_b_o), 32'd0);
    check("midrst_acc", 32'(acc_en_o), 32'd0);
    check("midrst_busy", 32'(busy_o), 32'd0);
    check("midrst_done", 32'(tile_done_o), 32'd0);
    qa.delete();
    qb.delete();
    @(negedge clk);
    rstn = 1'b1;
    #1;
    check("midrst_ready", 32'(load_ready_o), 32'd1);
    check("midrst_busy_after", 32'(busy_o), 32'd0);
    @(negedge clk);
    rand_tile();
    apply_stimulus();
    handshake(1'b0);
    check_output("fresh", -1);
    finish_tile("fresh", 2, 1'b0);

    // Randomized tiles and done latencies
    for (int n = 0; n < 6; n++) begin
      rand_tile();
      apply_stimulus();
      handshake(1'b0);
      check_output("rand", int'($urandom_range(0, BEATS)) - 1);
      finish_tile("rand", int'($urandom_range(0, 4)), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/systolic_input_feeder.md
Name: systolic_input_feeder

Overview:
Upstream stage of process_element. Accepts one A tile (N rows x K) and one B tile (K x N columns) through a valid/ready handshake. Replays the tiles as diagonally skewed, zero-padded operand streams, one element per lane per cycle, and drives acc_en for the PE array. It then waits for the array's done pulse before accepting the next tile.

Parameters:
MAC_WIDTH, 9, width of one operand element (8-bit value plus sign); bits pass through unmodified.
N, 2, array dimension: number of A row lanes and number of B column lanes.
K, 2, inner (reduction) dimension: number of elements per lane per tile.

Ports:
clk  input  1  clock, all state updates on rising edge.
rstn  input  1  asynchronous active-low reset.
load_valid_i  input  1  tile_a_i and tile_b_i are valid.
load_ready_o  output  1  feeder can accept a tile; high only in IDLE.
tile_a_i  input  N*K*MAC_WIDTH  A[i][k] at bits [(i*K+k)*MAC_WIDTH +: MAC_WIDTH].
tile_b_i  input  K*N*MAC_WIDTH  B[k][j] at bits [(k*N+j)*MAC_WIDTH +: MAC_WIDTH].
data_a_o  output  N*MAC_WIDTH  registered A stream; lane i at [i*MAC_WIDTH +: MAC_WIDTH].
data_b_o  output  N*MAC_WIDTH  registered B stream; lane j at [j*MAC_WIDTH +: MAC_WIDTH].
acc_en_o  output  1  PE accumulate enable; high on every streamed beat.
pe_done_i  input  1  done pulse from process_element.
busy_o  output  1  high in STREAM or WAIT_DONE.
tile_done_o  output  1  one-cycle pulse when the tile is fully processed.

Behaviour:
- Reset (async, rstn=0): state=IDLE, beat counter=0, tile registers=0. data_a_o=0, data_b_o=0, acc_en_o=0, busy_o=0, tile_done_o=0, load_ready_o=1 once rstn=1.
- Reset asserted mid-STREAM or mid-WAIT_DONE discards the tile. Outputs go to their reset values immediately, not at the next edge.
- States: IDLE, STREAM, WAIT_DONE.
- IDLE: load_ready_o=1. A handshake occurs on an edge where load_valid_i=1 and load_ready_o=1. On that edge:
  - capture both tiles;
  - beat counter t:=0;
  - load the t=0 values into data_a_o and data_b_o;
  - acc_en_o:=1, busy_o:=1, state:=STREAM.
- First streamed beat is visible in the cycle after the handshake edge (latency 1).
- Beat values at beat t, for t = 0 .. K+N-2:
  - A lane i = A[i][t-i] if 0 <= t-i < K, else 0.
  - B lane j = B[t-j][j] if 0 <= t-j < K, else 0.
  - This is the lane-i / lane-j delay-by-index skew; zero padding fills the leading and trailing triangles.
- STREAM: each edge advances t and loads the next beat's values. On the edge after beat K+N-2: data outputs:=0, acc_en_o:=0, state:=WAIT_DONE.
- acc_en_o is high for exactly K+N-1 consecutive cycles per tile.
- pe_done_i is ignored in IDLE and STREAM and sampled only in WAIT_DONE.
- WAIT_DONE: on an edge with pe_done_i=1: tile_done_o:=1 for one cycle, busy_o:=0, state:=IDLE. load_ready_o rises in the same cycle as the tile_done_o pulse.
- load_valid_i while load_ready_o=0 is ignored; tile inputs are not sampled.
- Back-to-back tiles: minimum spacing between handshakes is K+N-1 + (cycles in WAIT_DONE) + 1.
- Counter width is clog2(K+N-1), minimum 1 bit. No wrap-around: the counter is reset on every handshake.
- No arithmetic on data; sign bits are preserved bit-exactly.

Test Plan:
- Reset: rstn low mid-cycle with load_valid_i=0 -> all outputs 0 immediately; load_ready_o=1 after release; busy_o=0.
- Basic skew, N=2, K=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]], handshake at edge E:
  - cycles E+1..E+3: data_a lane0 = 1,2,0; lane1 = 0,3,4.
  - data_b lane0 = 5,7,0; lane1 = 0,6,8.
  - acc_en_o = 1,1,1, then 0.
- All-ones tile -> lane0 = 1,1,0 and lane1 = 0,1,1 for both A and B. pe_done_i 5 cycles later -> tile_done_o pulses exactly one cycle; load_ready_o=1 in that cycle.
- Negative operands: A[0][0]=9'h1FF (-1) -> data_a lane0 = 9'h1FF at beat 0, bit-exact.
- Protocol:
  - load_valid_i held high through STREAM with a different tile -> second tile accepted only on the first edge after tile_done_o; no output corruption.
  - pe_done_i pulsed during STREAM -> ignored; state still reaches WAIT_DONE.
- Reset at beat 1 of STREAM -> outputs 0 immediately; after release load_ready_o=1; a fresh tile streams correctly from beat 0.
